// File: rtl/theta_stage_pkg.sv
// Shared constants, slice bit indexing and FSM encoding for the theta stage.
package theta_stage_pkg;

   localparam int SLICE_W = 25;
   localparam int SLICES  = 64;
   localparam int COLS    = 5;
   localparam int CNT_W   = $clog2(SLICES);

   typedef enum logic [0:0] {
      ST_LOAD = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   // Bit position of lane (x, y) inside a slice.
   function automatic int idx(input int x, input int y);
      return 32'sd5 * y + x;
   endfunction

endpackage

// File: rtl/theta_slice_mix.sv
// Combinational column mix of one slice from its own parity and the previous slice's parity.
module theta_slice_mix
   import theta_stage_pkg::*;
(
   input  logic [SLICE_W-1:0] slice,
   input  logic [COLS-1:0]    parCur,
   input  logic [COLS-1:0]    parPrev,
   output logic [SLICE_W-1:0] mixed
);

   logic [COLS-1:0] d_s;

   // Column correction D[x] applied to every row y of the slice.
   always_comb begin
      d_s   = '0;
      mixed = '0;
      for (int x = 0; x < COLS; x++) begin
         d_s[x] = parCur[(x + COLS - 1) % COLS] ^ parPrev[(x + 1) % COLS];
      end
      for (int y = 0; y < COLS; y++) begin
         for (int x = 0; x < COLS; x++) begin
            mixed[idx(x, y)] = slice[idx(x, y)] ^ d_s[x];
         end
      end
   end

endmodule

// File: rtl/theta_stage.sv
// Theta column-parity stage: buffers a 64-slice state, then streams mixed slices z = 0..63.
// Optional THETA_BYPASS_EN adds a per-block bypass input that emits the buffered slices unmodified.
module theta_stage
   import theta_stage_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
`ifdef THETA_BYPASS_EN
   input  logic               bypass,
`endif
   input  logic               inValid,
   output logic               inReady,
   input  logic [SLICE_W-1:0] inData,
   output logic               outValid,
   input  logic               outReady,
   output logic [SLICE_W-1:0] outData,
   output logic               busy,
   output logic               done
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLICES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   function automatic logic [COLS-1:0] col_parity(input logic [SLICE_W-1:0] s);
      logic [COLS-1:0] p;
      p = '0;
      for (int x = 0; x < COLS; x++) begin
         for (int y = 0; y < COLS; y++) begin
            p[x] = p[x] ^ s[idx(x, y)];
         end
      end
      return p;
   endfunction

   state_t             state_r, state_nxt_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [SLICE_W-1:0] buf_r [SLICES];
   logic [COLS-1:0]    par_r [SLICES];
   logic               done_r;
   logic               in_fire_s, out_fire_s, last_s;
   logic [SLICE_W-1:0] mixed_s;

   assign last_s = (cnt_r == CNT_LAST);

   // Handshake decode and next-state selection.
   always_comb begin
      state_nxt_s = state_r;
      in_fire_s   = 1'b0;
      out_fire_s  = 1'b0;
      inReady     = 1'b0;
      outValid    = 1'b0;
      busy        = 1'b0;
      case (state_r)
         ST_LOAD: begin
            inReady   = 1'b1;
            in_fire_s = inValid;
            if (inValid && last_s) begin
               state_nxt_s = ST_EMIT;
            end else begin
               state_nxt_s = ST_LOAD;
            end
         end
         ST_EMIT: begin
            outValid   = 1'b1;
            busy       = 1'b1;
            out_fire_s = outReady;
            if (outReady && last_s) begin
               state_nxt_s = ST_LOAD;
            end else begin
               state_nxt_s = ST_EMIT;
            end
         end
         default: begin
            state_nxt_s = ST_LOAD;
         end
      endcase
   end

   // FSM state, slice counter and end-of-block pulse; cnt wraps naturally at SLICES.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_LOAD;
         cnt_r   <= '0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         done_r  <= out_fire_s && last_s;
         if (in_fire_s || out_fire_s) begin
            cnt_r <= cnt_r + CNT_ONE;
         end
      end
   end

   // Slice buffer and per-slice column parity file, written during LOAD.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int z = 0; z < SLICES; z++) begin
            buf_r[z] <= '0;
            par_r[z] <= '0;
         end
      end else if (in_fire_s) begin
         buf_r[cnt_r] <= inData;
         par_r[cnt_r] <= col_parity(inData);
      end
   end

   // Slice z mixes with slice z-1; z = 0 wraps to slice 63.
   theta_slice_mix u_mix (
      .slice   (buf_r[cnt_r]),
      .parCur  (par_r[cnt_r]),
      .parPrev (par_r[cnt_r - CNT_ONE]),
      .mixed   (mixed_s)
   );

`ifdef THETA_BYPASS_EN
   logic bypass_r;

   // Bypass choice is latched on the first transfer and held for the block.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bypass_r <= 1'b0;
      end else if (in_fire_s && (cnt_r == '0)) begin
         bypass_r <= bypass;
      end
   end

   assign outData = bypass_r ? buf_r[cnt_r] : mixed_s;
`else
   assign outData = mixed_s;
`endif

   assign done = done_r;

endmodule
